audio_clip_player: RTL
======================

Name: audio_clip_player

Overview:
- Parametrised multi-clip sample player. Replaces the single-clip, always-looping ROM address counter.
- Holds a table of NUM_CLIPS start/end regions in one shared sample ROM. It plays the selected clip either once or looped, at a programmable sample period, with gain and stereo options.
- Sits between the game-control logic, the sample ROM (1-cycle read latency) and Audio_Controller. It drives Audio_Controller's write_audio_out and channel data directly.

Parameters:
- ADDR_W, 18, ROM address width.
- SAMPLE_W, 6, ROM sample width; unsigned, MSB-aligned into 32-bit output.
- NUM_CLIPS, 4, number of clip regions.
- SEL_W, 2, width of clip_sel; must satisfy 2^SEL_W >= NUM_CLIPS.
- CLIP_START, {18'd83255,18'd66983,18'd16396,18'd0}, packed NUM_CLIPS*ADDR_W; clip i occupies bits [i*ADDR_W +: ADDR_W].
- CLIP_END, {18'd137138,18'd83254,18'd66982,18'd16395}, packed, same layout; CLIP_END[i] >= CLIP_START[i].
- DIV, 1200, CLOCK_50 cycles per sample; must be >= 3.
- STEREO, 1, 1: right channel = left channel; 0: right channel = 0.

Ports:
- CLOCK_50  in  1  system clock; all logic is on its rising edge.
- resetn  in  1  synchronous reset, active-low.
- trigger  in  1  single-cycle start request.
- clip_sel  in  SEL_W  clip index; sampled when trigger is high.
- loop_en  in  1  sampled with trigger; 1 = loop until stopped.
- stop  in  1  single-cycle abort.
- gain  in  2  attenuation: output arithmetic right shift by gain (0..3).
- rom_addr  out  ADDR_W  sample ROM address.
- rom_q  in  SAMPLE_W  ROM data; valid 1 cycle after rom_addr.
- audio_out_allowed  in  1  Audio_Controller output-FIFO space.
- write_audio_out  out  1  push strobe to Audio_Controller.
- left_channel_audio_out  out  32  left sample.
- right_channel_audio_out  out  32  right sample.
- busy  out  1  high while a clip is playing.
- active_clip  out  SEL_W  index of the latched clip.
- done  out  1  one-cycle pulse at natural end of a one-shot clip.

Behaviour:
- Reset (resetn=0 at a clock edge), including mid-play:
  - state=IDLE.
  - rom_addr, sample register, both channel outputs, busy, done, active_clip and write_audio_out all 0.
  - Cycle counter cleared.
- States:
  - IDLE: wait for a valid trigger.
  - FETCH: rom_addr holds the current address.
  - LATCH: capture rom_q into the sample register.
  - HOLD: count DIV-2 cycles.
  - Each sample therefore spans exactly DIV cycles (FETCH 1 + LATCH 1 + HOLD DIV-2).
- Trigger acceptance: a trigger with clip_sel < NUM_CLIPS, accepted in any state:
  - latch clip_sel into active_clip and loop_en into the loop flag;
  - rom_addr <= CLIP_START[clip_sel]; busy <= 1; next state = FETCH.
  - Retrigger during play restarts immediately with the new clip.
  - A trigger with clip_sel >= NUM_CLIPS is ignored.
- stop: in any non-IDLE state, go to IDLE, busy <= 0, no done pulse, sample register cleared.
  - stop and trigger in the same cycle: stop wins and the trigger is dropped.
- End of HOLD:
  - If rom_addr != CLIP_END[active_clip]: rom_addr + 1, go to FETCH.
  - If rom_addr == CLIP_END[active_clip] and loop flag = 1: rom_addr <= CLIP_START, go to FETCH (seamless wrap, no extra cycles).
  - If rom_addr == CLIP_END[active_clip] and loop flag = 0: go to IDLE, busy <= 0, done = 1 for one cycle, sample register cleared.
- Single-sample clip (START == END): plays one sample period, then the wrap or done rule above applies.
- Output data:
  - left = ({sample_reg, (32-SAMPLE_W) zeros}) >>> gain, treated as signed 32-bit.
  - right = left if STEREO=1, else 0.
  - Outputs are registered and change only on the cycle after LATCH.
- Handshake: write_audio_out = busy & audio_out_allowed, combinational.
  - The held sample is repeated into the FIFO at the codec rate.
  - When audio_out_allowed=0 no write occurs; playback timing is unaffected (no stall).
- In IDLE, channel outputs are 0 and write_audio_out is 0.

Test Plan:
- Setup for all scenarios: DIV=4, NUM_CLIPS=2, CLIP_START={8,0}, CLIP_END={10,2}, ROM q = address value, audio_out_allowed=1, gain=0.
- One-shot clip 0: trigger with clip_sel=0, loop_en=0 -> rom_addr 0,1,2, each held 4 cycles; left = {addr, 26'b0}; done pulses once, 12 cycles after trigger; busy then 0; write_audio_out 0.
- Loop clip 1: trigger with loop_en=1 -> address sequence 8,9,10,8,9,... with no gap at the wrap; done never asserts; stop at address 9 -> next cycle IDLE, busy=0, outputs 0, no done.
- Retrigger: clip 0 playing at address 1, trigger clip_sel=1 -> next cycle rom_addr=8, active_clip=1. Same cycle trigger+stop -> IDLE, trigger dropped. clip_sel=3 -> ignored.
- Gain/stereo: sample 6'b100000, gain=2 -> left=32'hE0000000; STEREO=0 -> right=0; STEREO=1 -> right=left.
- Backpressure/reset: audio_out_allowed toggled -> write_audio_out tracks it while busy and the address timing is unchanged; resetn=0 mid-HOLD -> next edge all outputs 0, state IDLE.

Source files
------------

// File: rtl/audio_clip_player.sv
// Multi-clip sample player: plays one of NUM_CLIPS ROM regions once or looped,
// one sample per DIV clocks, with gain and optional stereo duplication.
//
// Ports:
//   CLOCK_50, resetn        clock, synchronous active-low reset
//   trigger, clip_sel       start request and clip index
//   loop_en, stop           loop mode (sampled with trigger), abort
//   gain                    output arithmetic right shift (0..3)
//   rom_addr, rom_q         sample ROM address / data (1-cycle latency)
//   audio_out_allowed       codec FIFO has space
//   write_audio_out         FIFO push strobe
//   left/right_channel_audio_out  32-bit channel samples
//   busy, active_clip, done status: playing, latched clip, one-shot end pulse
module audio_clip_player #(
    parameter int ADDR_W    = 18,
    parameter int SAMPLE_W  = 6,
    parameter int NUM_CLIPS = 4,
    parameter int SEL_W     = 2,
    parameter logic [NUM_CLIPS*ADDR_W-1:0] CLIP_START =
        {18'd83255, 18'd66983, 18'd16396, 18'd0},
    parameter logic [NUM_CLIPS*ADDR_W-1:0] CLIP_END =
        {18'd137138, 18'd83254, 18'd66982, 18'd16395},
    parameter int DIV       = 1200,
    parameter bit STEREO    = 1'b1
) (
    input  logic                CLOCK_50,
    input  logic                resetn,
    input  logic                trigger,
    input  logic [SEL_W-1:0]    clip_sel,
    input  logic                loop_en,
    input  logic                stop,
    input  logic [1:0]          gain,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [SAMPLE_W-1:0] rom_q,
    input  logic                audio_out_allowed,
    output logic                write_audio_out,
    output logic [31:0]         left_channel_audio_out,
    output logic [31:0]         right_channel_audio_out,
    output logic                busy,
    output logic [SEL_W-1:0]    active_clip,
    output logic                done
);

    typedef enum logic [1:0] {IDLE, FETCH, LATCH, HOLD} state_t;

    localparam int CNT_W = $clog2(DIV);
    // HOLD lasts DIV-2 cycles, so its last cycle has count DIV-3.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(DIV - 3);

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [SAMPLE_W-1:0] sample_reg, sample_n;
    logic [ADDR_W-1:0]   addr_n;
    logic [31:0]         left_n, right_n;
    logic                busy_n, done_n, loop_q, loop_n;
    logic [SEL_W-1:0]    clip_n;
    logic signed [31:0]  aligned, shaped;
    logic                trig_ok;

    function automatic logic [ADDR_W-1:0] start_of(input logic [SEL_W-1:0] i);
        return CLIP_START[int'(i)*ADDR_W +: ADDR_W];
    endfunction

    function automatic logic [ADDR_W-1:0] end_of(input logic [SEL_W-1:0] i);
        return CLIP_END[int'(i)*ADDR_W +: ADDR_W];
    endfunction

    assign trig_ok = trigger && (int'(clip_sel) < NUM_CLIPS);
    assign aligned = $signed({rom_q, {(32-SAMPLE_W){1'b0}}});
    assign shaped  = aligned >>> gain;
    assign write_audio_out = busy & audio_out_allowed;

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state                   <= IDLE;
            cnt                     <= '0;
            sample_reg              <= '0;
            rom_addr                <= '0;
            left_channel_audio_out  <= '0;
            right_channel_audio_out <= '0;
            busy                    <= 1'b0;
            done                    <= 1'b0;
            active_clip             <= '0;
            loop_q                  <= 1'b0;
        end else begin
            state                   <= state_n;
            cnt                     <= cnt_n;
            sample_reg              <= sample_n;
            rom_addr                <= addr_n;
            left_channel_audio_out  <= left_n;
            right_channel_audio_out <= right_n;
            busy                    <= busy_n;
            done                    <= done_n;
            active_clip             <= clip_n;
            loop_q                  <= loop_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        sample_n = sample_reg;
        addr_n   = rom_addr;
        left_n   = left_channel_audio_out;
        right_n  = right_channel_audio_out;
        busy_n   = busy;
        done_n   = 1'b0;
        clip_n   = active_clip;
        loop_n   = loop_q;
        if (stop) begin
            // stop always drops a coincident trigger
            if (state != IDLE) begin
                state_n  = IDLE;
                cnt_n    = '0;
                busy_n   = 1'b0;
                sample_n = '0;
                left_n   = '0;
                right_n  = '0;
            end
        end else if (trig_ok) begin
            clip_n  = clip_sel;
            loop_n  = loop_en;
            addr_n  = start_of(clip_sel);
            busy_n  = 1'b1;
            cnt_n   = '0;
            state_n = FETCH;
        end else begin
            unique case (state)
                IDLE: ;
                FETCH: state_n = LATCH;
                LATCH: begin
                    // rom_q now reflects the address driven during FETCH
                    sample_n = rom_q;
                    left_n   = shaped;
                    right_n  = STEREO ? shaped : '0;
                    cnt_n    = '0;
                    state_n  = HOLD;
                end
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        cnt_n = '0;
                        if (rom_addr != end_of(active_clip)) begin
                            addr_n  = rom_addr + ADDR_W'(1);
                            state_n = FETCH;
                        end else if (loop_q) begin
                            addr_n  = start_of(active_clip);
                            state_n = FETCH;
                        end else begin
                            state_n  = IDLE;
                            busy_n   = 1'b0;
                            done_n   = 1'b1;
                            sample_n = '0;
                            left_n   = '0;
                            right_n  = '0;
                        end
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule
